// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding selects, data/HI-LO stall and
// the multiply/divide busy counter that backs the HI-LO interlock.
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_Rs,
    input  logic [4:0] D_Rt,
    input  logic [1:0] D_RsTuse,
    input  logic [1:0] D_RtTuse,
    input  logic       D_UseHILO,
    input  logic [4:0] E_Rs,
    input  logic [4:0] E_Rt,
    input  logic [4:0] E_WReg,
    input  logic [1:0] E_Tnew,
    input  logic       E_MDStart,
    input  logic       E_MDType,
    input  logic [4:0] M_Rt,
    input  logic [4:0] M_WReg,
    input  logic [1:0] M_Tnew,
    input  logic       M_Link,
    input  logic [4:0] W_WReg,
    output logic       Stall,
    output logic       FlushE,
    output logic [1:0] ForwardRSD,
    output logic [1:0] ForwardRTD,
    output logic [1:0] ForwardRSE,
    output logic [1:0] ForwardRTE,
    output logic       ForwardRTM,
    output logic       MDBusy,
    output logic [3:0] MDCount
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    // $0 is hardwired to zero, so it never counts as a producer.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_decode(input logic [4:0] src,
                                              input logic [4:0] m_wreg,
                                              input logic [1:0] m_tnew,
                                              input logic       m_link);
        logic [1:0] sel;
        sel = 2'b00;
        if (reg_match(m_wreg, src) && (m_tnew == 2'd0)) begin
            sel = m_link ? 2'b10 : 2'b01;
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_execute(input logic [4:0] src,
                                               input logic [4:0] m_wreg,
                                               input logic [1:0] m_tnew,
                                               input logic       m_link,
                                               input logic [4:0] w_wreg);
        logic [1:0] sel;
        sel = 2'b00;
        if (reg_match(m_wreg, src) && (m_tnew == 2'd0)) begin
            sel = m_link ? 2'b11 : 2'b10;
        end else if (reg_match(w_wreg, src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Tuse of 3 can never be below a 2-bit Tnew, so unused operands drop out.
    function automatic logic operand_hazard(input logic [4:0] src,
                                            input logic [1:0] tuse,
                                            input logic [4:0] e_wreg,
                                            input logic [1:0] e_tnew,
                                            input logic [4:0] m_wreg,
                                            input logic [1:0] m_tnew);
        return (reg_match(e_wreg, src) && (tuse < e_tnew)) ||
               (reg_match(m_wreg, src) && (tuse < m_tnew));
    endfunction

    logic [3:0] md_count_q;
    logic [3:0] md_count_d;
    logic       md_busy;
    logic       data_stall;
    logic       md_stall;

    always_comb begin
        md_count_d = md_count_q;
        if (E_MDStart && (md_count_q == 4'd0)) begin
            md_count_d = E_MDType ? DIV_LOAD : MULT_LOAD;
        end else if (md_count_q != 4'd0) begin
            md_count_d = md_count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_count_q <= '0;
        end else begin
            md_count_q <= md_count_d;
        end
    end

    always_comb begin
        md_busy    = (md_count_q != 4'd0) || E_MDStart;
        data_stall = operand_hazard(D_Rs, D_RsTuse, E_WReg, E_Tnew, M_WReg, M_Tnew) ||
                     operand_hazard(D_Rt, D_RtTuse, E_WReg, E_Tnew, M_WReg, M_Tnew);
        md_stall   = D_UseHILO && md_busy;
    end

    always_comb begin
        Stall      = data_stall || md_stall;
        FlushE     = data_stall || md_stall;
        ForwardRSD = fwd_decode(D_Rs, M_WReg, M_Tnew, M_Link);
        ForwardRTD = fwd_decode(D_Rt, M_WReg, M_Tnew, M_Link);
        ForwardRSE = fwd_execute(E_Rs, M_WReg, M_Tnew, M_Link, W_WReg);
        ForwardRTE = fwd_execute(E_Rt, M_WReg, M_Tnew, M_Link, W_WReg);
        ForwardRTM = !reg_match(W_WReg, M_Rt);
        MDBusy     = md_busy;
        MDCount    = md_count_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random pipeline
// states checked against a rule-level reference model.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] D_Rs, D_Rt;
    logic [1:0] D_RsTuse, D_RtTuse;
    logic       D_UseHILO;
    logic [4:0] E_Rs, E_Rt, E_WReg;
    logic [1:0] E_Tnew;
    logic       E_MDStart, E_MDType;
    logic [4:0] M_Rt, M_WReg;
    logic [1:0] M_Tnew;
    logic       M_Link;
    logic [4:0] W_WReg;
    logic       Stall, FlushE;
    logic [1:0] ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE;
    logic       ForwardRTM, MDBusy;
    logic [3:0] MDCount;

    int checks = 0;
    int errors = 0;
    int model_count = 0;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .D_Rs(D_Rs), .D_Rt(D_Rt), .D_RsTuse(D_RsTuse), .D_RtTuse(D_RtTuse),
        .D_UseHILO(D_UseHILO),
        .E_Rs(E_Rs), .E_Rt(E_Rt), .E_WReg(E_WReg), .E_Tnew(E_Tnew),
        .E_MDStart(E_MDStart), .E_MDType(E_MDType),
        .M_Rt(M_Rt), .M_WReg(M_WReg), .M_Tnew(M_Tnew), .M_Link(M_Link),
        .W_WReg(W_WReg),
        .Stall(Stall), .FlushE(FlushE),
        .ForwardRSD(ForwardRSD), .ForwardRTD(ForwardRTD),
        .ForwardRSE(ForwardRSE), .ForwardRTE(ForwardRTE),
        .ForwardRTM(ForwardRTM), .MDBusy(MDBusy), .MDCount(MDCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit producer(input logic [4:0] dst, input logic [4:0] src);
        return dst != 0 && dst == src;
    endfunction

    function automatic int exp_fwd_d(input logic [4:0] src);
        if (producer(M_WReg, src) && M_Tnew == 0) return M_Link ? 2 : 1;
        return 0;
    endfunction

    function automatic int exp_fwd_e(input logic [4:0] src);
        if (producer(M_WReg, src) && M_Tnew == 0) return M_Link ? 3 : 2;
        if (producer(W_WReg, src)) return 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit s;
        s = (producer(E_WReg, D_Rs) && D_RsTuse < E_Tnew) ||
            (producer(M_WReg, D_Rs) && D_RsTuse < M_Tnew) ||
            (producer(E_WReg, D_Rt) && D_RtTuse < E_Tnew) ||
            (producer(M_WReg, D_Rt) && D_RtTuse < M_Tnew);
        return s || (D_UseHILO && (model_count > 0 || E_MDStart));
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".Stall"},  8'(Stall),      8'(exp_stall()));
        chk({tag, ".FlushE"}, 8'(FlushE),     8'(exp_stall()));
        chk({tag, ".RSD"},    8'(ForwardRSD), 8'(exp_fwd_d(D_Rs)));
        chk({tag, ".RTD"},    8'(ForwardRTD), 8'(exp_fwd_d(D_Rt)));
        chk({tag, ".RSE"},    8'(ForwardRSE), 8'(exp_fwd_e(E_Rs)));
        chk({tag, ".RTE"},    8'(ForwardRTE), 8'(exp_fwd_e(E_Rt)));
        chk({tag, ".RTM"},    8'(ForwardRTM), 8'(!producer(W_WReg, M_Rt)));
        chk({tag, ".Busy"},   8'(MDBusy),     8'(model_count > 0 || E_MDStart));
        chk({tag, ".Count"},  8'(MDCount),    8'(model_count));
    endtask

    // Advance one clock; the model applies the counter rule to the inputs held across the edge.
    task automatic tick();
        @(posedge clk);
        if (reset) model_count = 0;
        else if (E_MDStart && model_count == 0) model_count = E_MDType ? 10 : 5;
        else if (model_count > 0) model_count = model_count - 1;
        #1;
    endtask

    task automatic idle();
        D_Rs = 0; D_Rt = 0; D_RsTuse = 3; D_RtTuse = 3; D_UseHILO = 0;
        E_Rs = 0; E_Rt = 0; E_WReg = 0; E_Tnew = 0; E_MDStart = 0; E_MDType = 0;
        M_Rt = 0; M_WReg = 0; M_Tnew = 0; M_Link = 0; W_WReg = 0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #2;
        chk("reset.Count", 8'(MDCount), 8'd0);
        chk("reset.Busy",  8'(MDBusy),  8'd0);
        tick();
        reset = 1'b0;
        tick();

        // load-use in E
        E_WReg = 8; E_Tnew = 2; D_Rs = 8; D_RsTuse = 1;
        #2;
        chk("lw_use.Stall",  8'(Stall),  8'd1);
        chk("lw_use.FlushE", 8'(FlushE), 8'd1);
        E_Tnew = 1;
        #2;
        chk("lw_use_t1.Stall", 8'(Stall), 8'd0);
        idle();

        // E-stage forwarding priority
        M_WReg = 9; M_Tnew = 0; W_WReg = 9; E_Rs = 9;
        #2;
        chk("fwd_e.M", 8'(ForwardRSE), 8'd2);
        M_Link = 1;
        #2;
        chk("fwd_e.link", 8'(ForwardRSE), 8'd3);
        M_WReg = 0;
        #2;
        chk("fwd_e.W", 8'(ForwardRSE), 8'd1);
        idle();

        // beq after jal
        D_Rs = 31; D_RsTuse = 0; M_WReg = 31; M_Tnew = 0; M_Link = 1;
        #2;
        chk("beq_jal.RSD",   8'(ForwardRSD), 8'd2);
        chk("beq_jal.Stall", 8'(Stall),      8'd0);
        idle();

        // $0 never stalls or forwards
        D_Rs = 0; E_WReg = 0; E_Tnew = 2; D_RsTuse = 0;
        #2;
        chk("zero.Stall", 8'(Stall), 8'd0);
        chk("zero.fwd",   8'({ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE}), 8'd0);
        idle();

        // mult busy window with a HI/LO reader waiting in D
        D_UseHILO = 1; E_MDStart = 1; E_MDType = 0;
        #2;
        chk("mult.t.Busy",  8'(MDBusy), 8'd1);
        chk("mult.t.Stall", 8'(Stall),  8'd1);
        tick();
        E_MDStart = 0;
        for (int k = 1; k <= 6; k++) begin
            #2;
            chk("mult.Count", 8'(MDCount), 8'(6 - k));
            chk("mult.Busy",  8'(MDBusy),  8'(k <= 5));
            chk("mult.Stall", 8'(Stall),   8'(k <= 5));
            tick();
        end
        idle();

        // async reset mid-divide
        E_MDStart = 1; E_MDType = 1;
        tick();
        E_MDStart = 0;
        for (int k = 0; k < 4; k++) tick();
        chk("div.pre_reset", 8'(MDCount), 8'd6);
        #2;
        reset = 1'b1;
        model_count = 0;
        #1;
        chk("div.reset.Count", 8'(MDCount), 8'd0);
        chk("div.reset.Busy",  8'(MDBusy),  8'd0);
        reset = 1'b0;
        tick();

        // restart ignored while busy
        E_MDStart = 1; E_MDType = 1;
        tick();
        E_MDStart = 0;
        for (int k = 0; k < 7; k++) tick();
        chk("div.at3", 8'(MDCount), 8'd3);
        E_MDStart = 1; E_MDType = 0;
        tick();
        E_MDStart = 0;
        chk("div.ign2", 8'(MDCount), 8'd2);
        tick();
        chk("div.ign1", 8'(MDCount), 8'd1);
        tick();
        chk("div.ign0", 8'(MDCount), 8'd0);

        // random pipeline states
        for (int n = 0; n < 1500; n++) begin
            D_Rs = 5'($urandom_range(3, 0));  D_Rt = 5'($urandom_range(3, 0));
            D_RsTuse = 2'($urandom);          D_RtTuse = 2'($urandom);
            D_UseHILO = 1'($urandom);
            E_Rs = 5'($urandom_range(3, 0));  E_Rt = 5'($urandom_range(3, 0));
            E_WReg = 5'($urandom_range(3, 0)); E_Tnew = 2'($urandom);
            E_MDStart = ($urandom_range(3, 0) == 0); E_MDType = 1'($urandom);
            M_Rt = 5'($urandom_range(3, 0));  M_WReg = 5'($urandom_range(3, 0));
            M_Tnew = 2'($urandom);            M_Link = 1'($urandom);
            W_WReg = 5'($urandom_range(3, 0));
            reset = ($urandom_range(63, 0) == 0);
            if (reset) model_count = 0;
            #2;
            check_all("rand");
            tick();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
